instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_fifo_if.sv | 16 +
 rtl/ifu_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and the prefetch entry type for the instruction fetch unit.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : ifu_pkg

// File: rtl/ifu_fifo_if.sv
// Control/data bundle between the fetch sequencer and its prefetch buffer.
interface ifu_fifo_if;
  import ifu_pkg::*;

  logic         push;
  logic         pop;
  logic         flush;
  fetch_entry_t push_entry;
  logic         full;
  logic         empty;
  fetch_entry_t head;

  modport master (output push, pop, flush, push_entry, input full, empty, head);
  modport slave  (input push, pop, flush, push_entry, output full, empty, head);

endinterface : ifu_fifo_if

// File: rtl/ifu_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, instr} with flush; DEPTH must be a power of two.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ifu_fifo_if.slave  fifo
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign fifo.full  = (count_q == CNT_W'(DEPTH));
  assign fifo.empty = (count_q == '0);
  assign fifo.head  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = fifo.pop && !fifo.empty;
    do_push  = fifo.push && (!fifo.full || do_pop);
    if (fifo.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observed once count covers it.
  always_ff @(posedge clk_i) begin
    if (do_push && !fifo.flush) mem_q[wr_ptr_q] <= fifo.push_entry;
  end

endmodule : ifu_fifo

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencer feeding a prefetch buffer toward decode.
// Optional macro IFU_HALT_ON_ZERO_EN stops fetch on an all-zero instruction word.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [ADDR_W-1:0]  addr_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               halted_o
);

  ifu_fifo_if fifo_if ();

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .fifo  (fifo_if)
  );

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop, fetch_go;

`ifdef IFU_HALT_ON_ZERO_EN
  logic halted_q, halted_d;
  assign halted_o = halted_q;
`else
  assign halted_o = 1'b0;
`endif

  assign addr_o  = pc_q;
  assign valid_o = !fifo_if.empty;
  assign instr_o = fifo_if.head.instr;
  assign pc_o    = fifo_if.head.pc;

  assign fifo_if.push       = push;
  assign fifo_if.pop        = pop;
  assign fifo_if.flush      = redirect_i;
  assign fifo_if.push_entry = '{pc: pc_q, instr: instr_i};

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    // Redirect wins: the head is not consumed in a redirect cycle.
    pop  = valid_o && ready_i && !redirect_i;
`ifdef IFU_HALT_ON_ZERO_EN
    halted_d = halted_q;
    fetch_go = !halted_q && !redirect_i && (!fifo_if.full || pop);
`else
    fetch_go = !redirect_i && (!fifo_if.full || pop);
`endif
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~ADDR_W'(3);
`ifdef IFU_HALT_ON_ZERO_EN
      halted_d = 1'b0;
`endif
    end else if (fetch_go) begin
`ifdef IFU_HALT_ON_ZERO_EN
      if (instr_i == '0) begin
        halted_d = 1'b1;
      end else begin
        push = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
`else
      push = 1'b1;
      pc_d = pc_q + PC_STEP;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q <= RESET_PC;
`ifdef IFU_HALT_ON_ZERO_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
`ifdef IFU_HALT_ON_ZERO_EN
      halted_q <= halted_d;
`endif
    end
  end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit; memory returns (addr>>2)+1.
module tb_instr_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic        redirect;
    logic        ready;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic        exp_halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, redirect, ready, zero_at_12;
  logic [31:0] rpc;
  logic [31:0] addr, instr, instr_o, pc_o;
  logic        valid, halted;
  logic [31:0] addr2, instr2, instr_o2, pc_o2;
  logic        valid2, halted2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  always_comb begin
    instr = (addr >> 2) + 32'd1;
    if (zero_at_12 && addr == 32'd12) instr = 32'd0;
  end
  assign instr2 = (addr2 >> 2) + 32'd1;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_n), .addr_o(addr), .instr_i(instr),
    .redirect_i(redirect), .redirect_pc_i(rpc), .valid_o(valid), .ready_i(ready),
    .instr_o(instr_o), .pc_o(pc_o), .halted_o(halted)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h100)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .addr_o(addr2), .instr_i(instr2),
    .redirect_i(redirect), .redirect_pc_i(rpc), .valid_o(valid2), .ready_i(ready),
    .instr_o(instr_o2), .pc_o(pc_o2), .halted_o(halted2)
  );

  function automatic vec_t mk(logic r, logic rd, logic rdy, logic [31:0] rp,
                              logic ev, logic [31:0] epc, logic [31:0] ein,
                              logic [31:0] ea, logic eh);
    vec_t v;
    v.rst_n = r; v.redirect = rd; v.ready = rdy; v.rpc = rp;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ein; v.exp_addr = ea;
    v.exp_halted = eh;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are compared before the next rising edge.
  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    rst_n = v.rst_n; redirect = v.redirect; ready = v.ready; rpc = v.rpc;
    #1;
    check({tag, ".valid"},  32'(valid),  32'(v.exp_valid));
    check({tag, ".addr"},   addr,        v.exp_addr);
    check({tag, ".halted"}, 32'(halted), 32'(v.exp_halted));
    if (v.exp_valid) begin
      check({tag, ".pc"},    pc_o,    v.exp_pc);
      check({tag, ".instr"}, instr_o, v.exp_instr);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; redirect = 1'b0; ready = 1'b0; rpc = '0; zero_at_12 = 1'b0;
    repeat (2) @(posedge clk);

    // Streaming from reset: one word per cycle.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, 1, 0, 1, 32'(4 * (k - 1)), 32'(k), 32'(4 * k), 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'd32, 32'd9, 32'd36, 0));
    // Back-pressure: buffer fills at 4 entries, PC parks at 16.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 8, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 12, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 16, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 16, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 4, 2, 20, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 8, 3, 24, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 12, 4, 28, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 16, 5, 32, 0));
    // Redirect to misaligned 0x43 while full.
    tbl.push_back(mk(1, 0, 0, 0, 1, 20, 6, 36, 0));
    tbl.push_back(mk(1, 1, 0, 32'h43, 1, 20, 6, 36, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h40, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'h40, 17, 32'h44, 0));
    // Redirect coinciding with a pop: no stale PCs afterwards.
    tbl.push_back(mk(1, 1, 1, 32'h80, 1, 32'h44, 18, 32'h48, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h80, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'h80, 33, 32'h84, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 32'h84, 34, 32'h88, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Mid-stream reset that also overrides a pending redirect.
    apply(mk(0, 1, 1, 32'h200, 1, 32'h88, 35, 32'h8c, 0), "rst_mid0");
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), "rst_mid1");
    check("rst_pc100.valid", 32'(valid2), 32'd0);
    check("rst_pc100.addr",  addr2,       32'h100);
    apply(mk(1, 0, 1, 0, 1, 0, 1, 4, 0), "rst_mid2");
    check("rst_pc100.valid2", 32'(valid2), 32'd1);
    check("rst_pc100.pc",     pc_o2,       32'h100);
    check("rst_pc100.instr",  instr_o2,    32'h41);
    check("rst_pc100.addr2",  addr2,       32'h104);

    // PC wrap at the top of the address space.
    apply(mk(1, 1, 1, 32'hFFFF_FFF8, 1, 4, 2, 8, 0), "wrap0");
    apply(mk(1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 0), "wrap1");
    apply(mk(1, 0, 1, 0, 1, 32'hFFFF_FFF8, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 0), "wrap2");
    apply(mk(1, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h4000_0000, 32'h0, 0), "wrap3");
    apply(mk(1, 0, 1, 0, 1, 0, 1, 4, 0), "wrap4");

    // Zero instruction word at address 12.
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; ready = 1'b1; zero_at_12 = 1'b1;
    @(posedge clk);
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), "zero0");
    apply(mk(1, 0, 1, 0, 1, 0, 1, 4, 0), "zero1");
    apply(mk(1, 0, 1, 0, 1, 4, 2, 8, 0), "zero2");
    apply(mk(1, 0, 1, 0, 1, 8, 3, 12, 0), "zero3");
`ifdef IFU_HALT_ON_ZERO_EN
    apply(mk(1, 0, 1, 0, 0, 0, 0, 12, 1), "halt4");
    apply(mk(1, 0, 1, 0, 0, 0, 0, 12, 1), "halt5");
    apply(mk(1, 1, 1, 0, 0, 0, 0, 12, 1), "halt6");
    zero_at_12 = 1'b0;
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), "halt7");
    apply(mk(1, 0, 1, 0, 1, 0, 1, 4, 0), "halt8");
`else
    apply(mk(1, 0, 1, 0, 1, 12, 0, 16, 0), "zero4");
    apply(mk(1, 0, 1, 0, 1, 16, 5, 20, 0), "zero5");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_instr_fetch_unit
